// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit block RAM port among NUM_REQ requesters.
// One transfer per cycle; read data is steered back via a one-hot pending flag.
module bram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*32-1:0]         REQ_WDATA,
  input  logic [NUM_REQ*4-1:0]          REQ_WE,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic [31:0]                   RSP_DATA,
  output logic [ADDR_WIDTH-1:0]         RAM_ADDR,
  output logic [31:0]                   RAM_DI,
  output logic [3:0]                    RAM_WE,
  output logic                          RAM_EN,
  input  logic [31:0]                   RAM_DO
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         r_ptr;
  logic [NUM_REQ-1:0]    r_rd_pend;

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [31:0]           w_wdata [NUM_REQ];
  logic [3:0]            w_we    [NUM_REQ];
  logic [PW-1:0]         w_win;
  logic                  w_any;
  logic                  w_xfer;
  logic [PW-1:0]         w_sel;
  logic [PW-1:0]         w_ptr_next;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_addr[gi]  = REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata[gi] = REQ_WDATA[gi*32 +: 32];
      assign w_we[gi]    = REQ_WE[gi*4 +: 4];
    end
  endgenerate

  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Scan from the farthest offset down so the candidate closest to r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (REQ_VALID[f_wrap(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = f_wrap(r_ptr, k);
      end
    end
  end

  assign w_xfer     = w_any & ~RST;
  assign w_sel      = w_xfer ? w_win : r_ptr;
  assign w_ptr_next = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    REQ_READY = '0;
    if (w_xfer) REQ_READY[w_win] = 1'b1;
  end

  // Idle cycles keep address/data parked on the r_ptr slice to cut toggling.
  assign RAM_EN   = w_xfer;
  assign RAM_ADDR = w_addr[w_sel];
  assign RAM_DI   = w_wdata[w_sel];
  assign RAM_WE   = w_xfer ? w_we[w_win] : 4'b0000;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr     <= '0;
      r_rd_pend <= '0;
    end else if (w_xfer) begin
      r_ptr     <= w_ptr_next;
      r_rd_pend <= '0;
      if (w_we[w_win] == 4'b0000) r_rd_pend[w_win] <= 1'b1;
    end else begin
      r_rd_pend <= '0;
    end
  end

  assign RSP_VALID = RST ? '0 : r_rd_pend;
  assign RSP_DATA  = RAM_DO;

endmodule
